// File: rtl/hdmi_vtg.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_vtg
//  Purpose  : Video timing generator for the HDMI output path. Waits until
//             the pixel PLL has held lock for LOCK_WAIT cycles, then produces
//             hsync, vsync, data enable, pixel coordinates and a frame-start
//             pulse. Defaults are CEA 1080p60 (2200x1125 total).
//  Options  : VTG_PATTERN_EN - adds a registered 8-bar colour test pattern
//             on the rgb port.
//  Revision : 1.0 - initial release
// ============================================================================
module hdmi_vtg #(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int LOCK_WAIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_lock,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        running
`ifdef VTG_PATTERN_EN
    ,
    output logic [23:0] rgb
`endif
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit thresholds so a total of exactly 4096 still compares cleanly
    localparam logic [12:0] c_h_act   = 13'(H_ACTIVE);
    localparam logic [12:0] c_hs_beg  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] c_hs_end  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] c_h_last  = 13'(c_h_total - 1);
    localparam logic [12:0] c_v_act   = 13'(V_ACTIVE);
    localparam logic [12:0] c_vs_beg  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] c_vs_end  = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] c_v_last  = 13'(c_v_total - 1);

    localparam int              c_lw        = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [c_lw-1:0] c_lock_last = c_lw'(LOCK_WAIT - 1);

    // Refuse to build if the 12-bit counters cannot hold the timing
    generate
        if (c_h_total > 4096 || c_v_total > 4096 || LOCK_WAIT < 1) begin : g_bad_params
            $error("hdmi_vtg: totals must not exceed 4096 and LOCK_WAIT must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_WAIT_LOCK = 1'b0,
        S_RUN       = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync;
    logic            w_lock_s;
    logic [c_lw-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic [11:0]     r_hcnt, w_hcnt_nxt;
    logic [11:0]     r_vcnt, w_vcnt_nxt;

    logic            w_out_en;
    logic            w_de, w_hs_act, w_vs_act, w_fs;

    logic            r_hs, r_vs, r_de, r_fs;
    logic [11:0]     r_x, r_y;

    // Two-flop synchronizer bringing PLL lock into the pixel clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_lock};
        end
    end

    assign w_lock_s = r_sync[1];

    // State, lock qualifier and raster counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT_LOCK;
            r_lock_cnt <= '0;
            r_hcnt     <= '0;
            r_vcnt     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_vcnt     <= w_vcnt_nxt;
        end
    end

    // Next-state logic: lock loss always wins over the qualifying count
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_hcnt_nxt     = r_hcnt;
        w_vcnt_nxt     = r_vcnt;
        case (r_state)
            S_WAIT_LOCK: begin
                w_hcnt_nxt = '0;
                w_vcnt_nxt = '0;
                if (!w_lock_s) begin
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == c_lock_last) begin
                    w_state_nxt    = S_RUN;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + c_lw'(1);
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    // abandon the partial frame; next run restarts at (0,0)
                    w_state_nxt    = S_WAIT_LOCK;
                    w_lock_cnt_nxt = '0;
                    w_hcnt_nxt     = '0;
                    w_vcnt_nxt     = '0;
                end else if ({1'b0, r_hcnt} == c_h_last) begin
                    w_hcnt_nxt = '0;
                    if ({1'b0, r_vcnt} == c_v_last) begin
                        w_vcnt_nxt = '0;
                    end else begin
                        w_vcnt_nxt = r_vcnt + 12'd1;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + 12'd1;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
            end
        endcase
    end

    // Timing decode of the current counter values
    always_comb begin
        w_out_en = (r_state == S_RUN) && w_lock_s;
        w_de     = ({1'b0, r_hcnt} < c_h_act) && ({1'b0, r_vcnt} < c_v_act);
        w_hs_act = ({1'b0, r_hcnt} >= c_hs_beg) && ({1'b0, r_hcnt} < c_hs_end);
        w_vs_act = ({1'b0, r_vcnt} >= c_vs_beg) && ({1'b0, r_vcnt} < c_vs_end);
        w_fs     = (r_hcnt == 12'd0) && (r_vcnt == 12'd0);
    end

    // Output register stage: one clock behind the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
            r_de <= 1'b0;
            r_fs <= 1'b0;
            r_x  <= '0;
            r_y  <= '0;
        end else if (w_out_en) begin
            r_hs <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs <= w_vs_act ? VS_POL : ~VS_POL;
            r_de <= w_de;
            r_fs <= w_fs;
            r_x  <= w_de ? r_hcnt : 12'd0;
            r_y  <= w_de ? r_vcnt : 12'd0;
        end else begin
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
            r_de <= 1'b0;
            r_fs <= 1'b0;
            r_x  <= '0;
            r_y  <= '0;
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_fs;
    assign running     = (r_state == S_RUN);

`ifdef VTG_PATTERN_EN
    localparam int c_bar_w = H_ACTIVE / 8;

    logic [2:0]  w_bar;
    logic [23:0] w_colour;
    logic [23:0] r_rgb;

    // Bar index from seven threshold compares instead of a divider
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, r_hcnt} >= 13'(k * c_bar_w)) begin
                w_bar = 3'(k);
            end
        end
        case (w_bar)
            3'd0:    w_colour = 24'hFFFFFF;
            3'd1:    w_colour = 24'hFFFF00;
            3'd2:    w_colour = 24'h00FFFF;
            3'd3:    w_colour = 24'h00FF00;
            3'd4:    w_colour = 24'hFF00FF;
            3'd5:    w_colour = 24'hFF0000;
            3'd6:    w_colour = 24'h0000FF;
            default: w_colour = 24'h000000;
        endcase
    end

    // Pattern pixel registered alongside de, black outside active video
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else if (w_out_en && w_de) begin
            r_rgb <= w_colour;
        end else begin
            r_rgb <= '0;
        end
    end

    assign rgb = r_rgb;
`endif

endmodule
`default_nettype wire

// File: doc/hdmi_vtg.md
# hdmi_vtg

Video timing generator for the HDMI output path. It runs on the pixel clock produced by the HDMI PLL and holds off until that PLL's lock output has been stable for a programmable time. It then produces hsync, vsync, data-enable and pixel coordinates for the HDMI encoder. Defaults give 1920x1080 (CEA 1080p60, 2200x1125 total).

## Interface
Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (clocks)
- H_SYNC, 44, hsync width (clocks)
- H_BP, 148, horizontal back porch (clocks)
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- LOCK_WAIT, 1024, consecutive locked cycles required before running (≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk, in, 1, pixel clock (PLL clkout0)
- rst, in, 1, asynchronous active-high reset
- pll_lock, in, 1, PLL lock, asynchronous to clk
- hs, out, 1, horizontal sync, level per HS_POL
- vs, out, 1, vertical sync, level per VS_POL
- de, out, 1, active-video enable
- x, out, 12, pixel column; 0 when de=0
- y, out, 12, pixel line; 0 when de=0
- frame_start, out, 1, one-cycle pulse coincident with de at pixel (0,0)
- running, out, 1, high while in RUN
- rgb, out, 24, test-pattern pixel {R,G,B}; exists only with VTG_PATTERN_EN

## Operation
- pll_lock passes through a 2-flop synchronizer to give lock_s.
- State machine:
  - WAIT_LOCK: lock_cnt counts consecutive cycles with lock_s=1 and clears to 0 on any lock_s=0. When lock_cnt reaches LOCK_WAIT-1 with lock_s=1, the block enters RUN with hcnt=0 and vcnt=0.
  - RUN: counters advance every cycle. If lock_s=0 in any cycle, the block returns to WAIT_LOCK immediately, clears lock_cnt and the counters, and forces outputs inactive on the next edge. A partial frame is abandoned, not completed.
- Counter ranges:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - At hcnt=H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - vcnt wraps to 0 after V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Region order within a line and within a frame: active, front porch, sync, back porch.
- Output decode (registered outputs; see Timing):
  - de = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE)
  - hs active when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC
  - vs active when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC; vs changes together with the line start (hcnt=0)
  - frame_start = (hcnt==0 && vcnt==0)
- Widths: counters are 12 bits. Parameter totals must not exceed 4096; this is checked at elaboration and the build fails if violated.
- Reset values: hs=~HS_POL, vs=~VS_POL, de=0, x=0, y=0, frame_start=0, running=0, rgb=0, state=WAIT_LOCK, counters=0.

## Timing
- Counter-to-output latency is 1 clock: the outputs at edge n+1 reflect the counter values at edge n.
- Lock to first output: a lock rise reaches lock_s after 2 clocks. RUN is entered after LOCK_WAIT further cycles. running rises on the same edge as the RUN entry, and frame_start/de first appear 1 clock after that.
- Lock loss to outputs: a lock fall reaches de=0, hs/vs inactive and running=0 within 3 clocks (2 synchronizer + 1 output register).
- Simultaneous events: a lock loss on the same cycle as the qualifying count wins, and the state stays in WAIT_LOCK.
- Throughput: one pixel per clock, with no gaps inside a line.

## Configuration
- VTG_PATTERN_EN defined:
  - Adds the rgb port, registered in the same stage as de.
  - Pattern is 8 equal vertical colour bars of width H_ACTIVE/8, using compare thresholds and no divider. Colour order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - rgb=0 whenever de=0.
- VTG_PATTERN_EN undefined: the rgb port and its logic are absent; all other behaviour is identical.

## Test plan
Small parameters are used: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), LOCK_WAIT=4, polarities 1.
- Reset, then pll_lock=1 at cycle 0: running rises at cycle 6, frame_start and de rise at cycle 7 with x=0, y=0. de stays high for 8 clocks (x=0..7); hs is high at hcnt 10..12.
- Full frame: de=1 in exactly 32 cycles per 128-cycle frame; vs is high for 32 cycles starting at the line with vcnt=5; frame_start pulses every 128 cycles.
- Glitchy lock (1 for 3 cycles, 0 for 1, then steady 1): RUN is entered 4 cycles after the steady rise is synchronized, not earlier.
- pll_lock drops mid-line (x=3): de=0, hs=vs=0 and running=0 within 3 clocks. On relock, the frame restarts at (0,0) with frame_start.
- rst asserted mid-frame: all outputs reach their reset values asynchronously, without waiting for a clock edge. After rst is released, the block waits in WAIT_LOCK for the full lock qualification.
- VTG_PATTERN_EN with H_ACTIVE=8: rgb is FFFFFF at x=0, FFFF00 at x=1, …, 000000 at x=7, and 0 during blanking.
